// File: rtl/blink_rtc_int.sv
// Blink real-time clock and interrupt controller: 5 ms tick prescaler, TIM0..TIM4
// cascade, timer status/mask/ack registers, INT enable and the registered int_n line.
`timescale 1ns/1ps

module blink_rtc_int #(
  parameter int unsigned TICK_DIV = 16384
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] io_a,
  input  logic [7:0] io_di,
  input  logic       com_restim,
  output logic [7:0] rd_data,
  output logic       rd_hit,
  output logic       int_n
);

  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

  localparam logic [7:0] PORT_INT  = 8'hB1;
  localparam logic [7:0] PORT_TACK = 8'hB4;
  localparam logic [7:0] PORT_TMK  = 8'hB5;
  localparam logic [7:0] PORT_TIM0 = 8'hD0;
  localparam logic [7:0] PORT_TIM1 = 8'hD1;
  localparam logic [7:0] PORT_TIM2 = 8'hD2;
  localparam logic [7:0] PORT_TIM3 = 8'hD3;
  localparam logic [7:0] PORT_TIM4 = 8'hD4;

  logic [15:0] presc;
  logic [7:0]  tim0;
  logic [5:0]  tim1;
  logic [7:0]  tim2;
  logic [7:0]  tim3;
  logic [4:0]  tim4;
  logic [2:0]  tsta;
  logic [2:0]  tmk;
  logic [7:0]  int_reg;
  logic        wr_prev;

  logic       tick;
  logic       sec_carry;
  logic       min_carry;
  logic       tim2_carry;
  logic       tim3_carry;
  logic       wr_strobe;
  logic       wr_en;
  logic [2:0] flag_set;
  logic [2:0] ack_bits;
  logic       int_pending;
  logic       int_unused;

  assign tick       = !com_restim && (presc == PRESC_LAST);
  assign sec_carry  = tick && (tim0 == 8'd199);
  assign min_carry  = sec_carry && (tim1 == 6'd59);
  assign tim2_carry = min_carry && (tim2 == 8'hFF);
  assign tim3_carry = tim2_carry && (tim3 == 8'hFF);

  assign flag_set    = {min_carry, sec_carry, tick};
  assign int_pending = |(tsta & tmk);
  assign int_unused  = ^int_reg[7:2];

  always_ff @(posedge clk) begin
    if (!reset_n || com_restim) begin
      presc <= 16'd0;
    end else if (tick) begin
      presc <= 16'd0;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  // The whole cascade advances in the tick cycle; com_restim pins it at zero.
  always_ff @(posedge clk) begin
    if (!reset_n || com_restim) begin
      tim0 <= 8'd0;
      tim1 <= 6'd0;
      tim2 <= 8'd0;
      tim3 <= 8'd0;
      tim4 <= 5'd0;
    end else begin
      if (tick)       tim0 <= sec_carry ? 8'd0 : tim0 + 8'd1;
      if (sec_carry)  tim1 <= min_carry ? 6'd0 : tim1 + 6'd1;
      if (min_carry)  tim2 <= tim2 + 8'd1;
      if (tim2_carry) tim3 <= tim3 + 8'd1;
      if (tim3_carry) tim4 <= tim4 + 5'd1;
    end
  end

  // A held strobe must write once only, so writes fire on its rising edge.
  assign wr_strobe = !iorq_n && !wr_n;
  assign wr_en     = wr_strobe && !wr_prev;
  assign ack_bits  = (wr_en && io_a == PORT_TACK) ? io_di[2:0] : 3'b000;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_prev <= 1'b0;
    end else begin
      wr_prev <= wr_strobe;
    end
  end

  // New flags are ORed in after the ack mask so a coincident set wins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tsta    <= 3'b000;
      tmk     <= 3'b000;
      int_reg <= 8'h00;
      int_n   <= 1'b1;
    end else begin
      tsta  <= (tsta & ~ack_bits) | flag_set;
      int_n <= !(int_reg[0] && int_reg[1] && int_pending);
      if (wr_en && io_a == PORT_INT) int_reg <= io_di;
      if (wr_en && io_a == PORT_TMK) tmk <= io_di[2:0];
    end
  end

  logic [7:0] port_data;
  logic       readable;

  always_comb begin
    port_data = 8'hFF;
    readable  = 1'b0;
    case (io_a)
      PORT_INT:  begin readable = 1'b1; port_data = {6'b0, int_pending, 1'b0}; end
      PORT_TMK:  begin readable = 1'b1; port_data = {5'b0, tsta};              end
      PORT_TIM0: begin readable = 1'b1; port_data = tim0;                      end
      PORT_TIM1: begin readable = 1'b1; port_data = {2'b0, tim1};              end
      PORT_TIM2: begin readable = 1'b1; port_data = tim2;                      end
      PORT_TIM3: begin readable = 1'b1; port_data = tim3;                      end
      PORT_TIM4: begin readable = 1'b1; port_data = {3'b0, tim4};              end
      default:   begin readable = 1'b0; port_data = 8'hFF;                     end
    endcase
  end

  assign rd_hit  = !iorq_n && !rd_n && readable;
  assign rd_data = rd_hit ? port_data : 8'hFF;

endmodule

// File: doc/blink_rtc_int.md
Name: blink_rtc_int

Overview:
- Blink real-time clock and interrupt controller for the Z88 core.
- Sits upstream of the tv80s CPU: drives its int_n input, which is currently tied high at top level.
- Returns IO read data that top level muxes onto z80_di during IO reads.
- Keeps the 5 ms tick / second / minute counters (TIM0..TIM4), the timer status/mask/ack registers and the INT enable register.

Parameters:
- TICK_DIV, 16384, clk cycles per 5 ms tick (3.2768 MHz core clock); legal range 2..65535.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- iorq_n  input  1  CPU IORQ, active low.
- rd_n  input  1  CPU RD, active low.
- wr_n  input  1  CPU WR, active low.
- io_a  input  8  CPU address low byte (IO port number).
- io_di  input  8  CPU data out (write data).
- com_restim  input  1  COM register bit 4; 1 = hold RTC in reset.
- rd_data  output  8  read data for decoded ports, combinational.
- rd_hit  output  1  1 while iorq_n=0, rd_n=0 and io_a is a readable port of this block.
- int_n  output  1  interrupt request to CPU, active low, registered.

Behaviour:
- Reset (reset_n=0 at clk edge):
  - prescaler, TIM0..TIM4, TSTA, TMK and INT all cleared to 0.
  - int_n=1; write-strobe history cleared.
- Prescaler:
  - 16-bit counter 0..TICK_DIV-1; tick pulse is 1 cycle when it wraps to 0.
- Counter cascade, all updated in the tick cycle:
  - TIM0 (8b): 0..199; increments on tick, wraps 199->0 with carry.
  - TIM1 (6b, read zero-extended): 0..59; increments on TIM0 carry, wraps 59->0 with carry.
  - TIM2 (8b) minutes: increments on TIM1 carry, wraps 255->0 with carry into TIM3 (8b).
  - TIM3 wraps 255->0 with carry into TIM4 (5b, read zero-extended); TIM4 wraps 31->0 silently.
- TSTA flags:
  - bit0 TICK set on every tick.
  - bit1 SEC set on TIM0 carry.
  - bit2 MIN set on TIM1 carry.
  - bits 7:3 read 0.
- com_restim=1:
  - prescaler and TIM0..TIM4 held at 0; no ticks, no new TSTA flags.
  - existing TSTA, TMK and INT unchanged.
  - Counting resumes from 0 the cycle after com_restim falls; first tick arrives TICK_DIV cycles later.
- IO writes:
  - wr_strobe = !iorq_n & !wr_n; a write is performed only in the first cycle wr_strobe is 1 (registered edge detect).
  - Holding the strobe for N cycles yields exactly one write.
  - Port B1 INT: INT <= io_di; bit0 GINT, bit1 TIME; other bits stored but unused.
  - Port B4 TACK: TSTA <= TSTA & ~io_di[2:0].
  - Port B5 TMK: TMK <= io_di[2:0].
  - Other ports ignored; D0..D3 writes belong to the segment registers at top level.
- Set beats clear: if a TACK write clears a bit in the same cycle that bit's flag sets, the bit ends at 1.
- IO reads, combinational from current register state, no side effects:
  - B1 STA: bit1 = |(TSTA & TMK), all other bits 0.
  - B5 TSTA.
  - D0..D4: TIM0..TIM4.
  - Other ports: rd_hit=0, rd_data=8'hFF.
- Interrupt:
  - int_n registered: int_n <= !(INT[0] & INT[1] & |(TSTA & TMK)).
  - Asserts 1 cycle after the flag/mask/enable condition becomes true.
  - Level-sensitive; stays low until acked via TACK, masked, or disabled.
- Reset mid-operation (reset_n low during a held write strobe):
  - registers cleared; edge detector cleared.
  - A strobe still low after reset counts as a new write on the first post-reset cycle.

Test Plan:
- TICK_DIV=4, run 4*200 cycles from reset -> TIM0 reads C7 just before the wrap, then 00; TIM1=1; TSTA reads 03.
- TMK=01, INT=03, wait one tick -> int_n low 1 cycle after the TICK flag sets; write TACK=01 -> int_n high next cycle; STA bit1 tracks |(TSTA&TMK).
- Hold iorq_n=0, wr_n=0, io_a=B4 for 5 cycles while a tick occurs on cycle 3 -> TSTA bit0=1 afterwards, since only the first cycle wrote.
- TACK write coincident with a tick -> TSTA bit0 remains 1.
- Preload the counters to 59:59 via cascade, assert com_restim for 10 cycles -> TIM0..TIM4 read 0, TSTA unchanged; after release, first tick after exactly TICK_DIV cycles.
- Read port 00 -> rd_hit=0, rd_data=FF; read D4 after a TIM3 wrap -> 01.
